// File: rtl/lc4_wb_arbiter_pkg.sv
// lc4_wb_pkg: shared types and sizes for the LC4 writeback-port arbiter.
package lc4_wb_pkg;

  localparam int REG_W = 3;
  localparam int REG_N = 8;
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  // One-hot mask selecting a single register of the file.
  function automatic logic [REG_N-1:0] reg_mask(input logic [REG_W-1:0] idx);
    reg_mask = REG_N'(1) << idx;
  endfunction

endpackage

// File: rtl/lc4_wb_arbiter_if.sv
// lc4_wb_arbiter_if: request, handshake, write-port and read-bypass signals
// of the writeback arbiter. master = requesters/regfile side, slave = arbiter.
interface lc4_wb_arbiter_if #(
  parameter int n = 16
);
  import lc4_wb_pkg::*;

  logic             a_we;
  logic [REG_W-1:0] a_rd;
  logic [n-1:0]     a_data;
  logic             o_a_stall;

  logic             b_valid;
  logic [REG_W-1:0] b_rd;
  logic [n-1:0]     b_data;
  logic             o_b_ready;

  logic             b_issue;
  logic [REG_W-1:0] b_issue_rd;

  logic [REG_W-1:0] o_rd;
  logic [n-1:0]     o_wdata;
  logic             o_rd_we;

  logic [REG_N-1:0] o_busy;
  logic             o_err;

  logic [REG_W-1:0] i_rs;
  logic [REG_W-1:0] i_rt;
  logic [n-1:0]     i_rs_data;
  logic [n-1:0]     i_rt_data;
  logic [n-1:0]     o_rs_data;
  logic [n-1:0]     o_rt_data;

  modport master (
    output a_we, a_rd, a_data, b_valid, b_rd, b_data, b_issue, b_issue_rd,
           i_rs, i_rt, i_rs_data, i_rt_data,
    input  o_a_stall, o_b_ready, o_rd, o_wdata, o_rd_we, o_busy, o_err,
           o_rs_data, o_rt_data
  );

  modport slave (
    input  a_we, a_rd, a_data, b_valid, b_rd, b_data, b_issue, b_issue_rd,
           i_rs, i_rt, i_rs_data, i_rt_data,
    output o_a_stall, o_b_ready, o_rd, o_wdata, o_rd_we, o_busy, o_err,
           o_rs_data, o_rt_data
  );

endinterface

// File: rtl/Nbit_reg.sv
// Nbit_reg: generic state register, synchronous active-high reset to zero,
// updates only when both the local and the global write enable are high.
module Nbit_reg #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic         we,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  // Reset wins over the enables so reset never waits on gwe.
  always_ff @(posedge clk) begin
    if (rst)             out <= '0;
    else if (gwe && we)  out <= in;
  end

endmodule

// File: rtl/lc4_wb_arbiter_scoreboard.sv
// lc4_wb_scoreboard: tracks registers with an outstanding long-latency result
// and flags protocol errors (double issue, completion to an idle register).
module lc4_wb_scoreboard
  import lc4_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  output logic [REG_N-1:0] busy,
  output logic             err
);

  logic [REG_N-1:0] set_mask;
  logic [REG_N-1:0] clr_mask;
  logic [REG_N-1:0] busy_next;
  logic             err_next;
  logic             dbl_issue;
  logic             idle_clr;

  // Set is OR-ed after the clear so a same-cycle set/clear leaves the bit set.
  always_comb begin
    set_mask  = set_en ? reg_mask(set_rd) : '0;
    clr_mask  = clr_en ? reg_mask(clr_rd) : '0;
    busy_next = (busy & ~clr_mask) | set_mask;
    dbl_issue = set_en && busy[set_rd] && !(clr_en && (clr_rd == set_rd));
    idle_clr  = clr_en && !busy[clr_rd];
    err_next  = err | dbl_issue | idle_clr;
  end

  Nbit_reg #(.n(REG_N)) busy_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .in(busy_next), .out(busy)
  );

  Nbit_reg #(.n(1)) err_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .in(err_next), .out(err)
  );

endmodule

// File: rtl/lc4_wb_arbiter.sv
// lc4_wb_arbiter: shares the regfile write port between the pipeline
// writeback (A, priority, no backpressure) and a long-latency unit (B,
// valid/ready). B is forced through after STARVE_LIMIT consecutive denials.
// Optional feature macro: LC4_WB_BYPASS_EN (forward the write data to reads).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_NORMAL | A has priority; B wins only when A is idle
// ST_FORCE  | B starved: A is stalled and B is written this cycle
module lc4_wb_arbiter
  import lc4_wb_pkg::*;
#(
  parameter int n            = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic gwe,
  lc4_wb_arbiter_if.slave bus
);

  state_t           state;
  state_t           next_state;
  logic             state_raw;
  logic             next_raw;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic             grant_b;
  logic             b_ready;
  logic             a_stall;
  logic [REG_W-1:0] rd_sel;
  logic [n-1:0]     wdata;
  logic             rd_we;

  assign state    = state_t'(state_raw);
  assign next_raw = next_state;

  Nbit_reg #(.n(1)) state_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .in(next_raw), .out(state_raw)
  );

  Nbit_reg #(.n(CNT_W)) cnt_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .in(cnt_next), .out(cnt)
  );

  // Arbitration, starvation counting and next-state selection.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    grant_b    = 1'b0;
    a_stall    = 1'b0;
    rd_sel     = '0;
    wdata      = '0;
    rd_we      = 1'b0;
    if (rst) begin
      next_state = ST_NORMAL;
      cnt_next   = '0;
    end else if (state == ST_FORCE) begin
      a_stall = 1'b1;
      if (bus.b_valid) begin
        grant_b = 1'b1;
        rd_sel  = bus.b_rd;
        wdata   = bus.b_data;
        rd_we   = 1'b1;
      end
      cnt_next   = '0;
      next_state = ST_NORMAL;
    end else begin
      if (bus.a_we) begin
        rd_sel = bus.a_rd;
        wdata  = bus.a_data;
        rd_we  = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
        rd_sel  = bus.b_rd;
        wdata   = bus.b_data;
        rd_we   = 1'b1;
      end
      if (grant_b) begin
        cnt_next = '0;
      end else if (bus.b_valid) begin
        cnt_next = cnt + 1'b1;
        if (cnt_next == CNT_W'(STARVE_LIMIT)) next_state = ST_FORCE;
      end
    end
    // Without gwe nothing commits, so B must not see its result accepted.
    b_ready = grant_b && gwe;
  end

  lc4_wb_scoreboard u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .gwe    (gwe),
    .set_en (bus.b_issue),
    .set_rd (bus.b_issue_rd),
    .clr_en (bus.b_valid && b_ready),
    .clr_rd (bus.b_rd),
    .busy   (bus.o_busy),
    .err    (bus.o_err)
  );

  assign bus.o_rd      = rd_sel;
  assign bus.o_wdata   = wdata;
  assign bus.o_rd_we   = rd_we;
  assign bus.o_b_ready = b_ready;
  assign bus.o_a_stall = a_stall;

`ifdef LC4_WB_BYPASS_EN
  assign bus.o_rs_data = (rd_we && (rd_sel == bus.i_rs)) ? wdata : bus.i_rs_data;
  assign bus.o_rt_data = (rd_we && (rd_sel == bus.i_rt)) ? wdata : bus.i_rt_data;
`else
  assign bus.o_rs_data = bus.i_rs_data;
  assign bus.o_rt_data = bus.i_rt_data;
`endif

endmodule

// File: doc/lc4_wb_arbiter.md
# lc4_wb_arbiter

Arbiter for the single write port of the 8-entry LC4 register file. It shares the port between the in-order pipeline writeback (requester A, highest priority, no backpressure) and a long-latency functional unit (requester B, valid/ready handshake). It also scoreboards registers with outstanding B results so the pipeline can interlock. It sits between the writeback stage / long-latency unit and the register file write inputs (`i_rd`, `i_wdata`, `i_rd_we`).

## Interface
Parameters:
- `n`, 16, data word width.
- `STARVE_LIMIT`, 4, consecutive denied B cycles before B is forced through; legal range 1..15.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `gwe` in 1: global write enable; qualifies every state update.
- `a_we` in 1: A write request.
- `a_rd` in 3: A destination register.
- `a_data` in n: A write data.
- `o_a_stall` out 1: A must hold its writeback this cycle; the write is not consumed.
- `b_valid` in 1: B result valid.
- `b_rd` in 3: B destination register.
- `b_data` in n: B write data.
- `o_b_ready` out 1: B result accepted this cycle.
- `b_issue` in 1: long-latency op issued this cycle.
- `b_issue_rd` in 3: destination register of the issued op.
- `o_rd` out 3: regfile write selector.
- `o_wdata` out n: regfile write data.
- `o_rd_we` out 1: regfile write enable.
- `o_busy` out 8: per-register outstanding-B-write mask.
- `o_err` out 1: sticky protocol-error flag.
- `i_rs`, `i_rt` in 3: read selectors, mirrored from the regfile.
- `i_rs_data`, `i_rt_data` in n: raw regfile read data.
- `o_rs_data`, `o_rt_data` out n: read data after optional bypass.

## Operation
- FSM states: NORMAL and FORCE. Starvation counter is 4 bits.
- NORMAL, `a_we`=1: grant A (`o_rd`=`a_rd`, `o_wdata`=`a_data`, `o_rd_we`=1). `o_b_ready`=0.
- NORMAL, `a_we`=0 and `b_valid`=1: grant B (`o_rd`=`b_rd`, `o_wdata`=`b_data`, `o_rd_we`=1). `o_b_ready`=1.
- NORMAL, neither request: `o_rd_we`=0, `o_rd`=0, `o_wdata`=0.
- Counter:
  - Increments on each gwe edge where `b_valid`=1 and `o_b_ready`=0.
  - Clears on a B handshake.
  - When the next counter value equals `STARVE_LIMIT`, next state is FORCE.
- FORCE:
  - `o_a_stall`=1; the A request is ignored, and A re-presents it next cycle.
  - Grant B with `o_b_ready`=1.
  - Counter clears; next state is NORMAL.
  - `o_a_stall`=0 in NORMAL.
- B protocol: once `b_valid` rises, B holds `b_valid`, `b_rd` and `b_data` stable until the handshake completes.
- Scoreboard:
  - `b_issue` sets `o_busy[b_issue_rd]`.
  - A B handshake clears `o_busy[b_rd]`.
  - Set and clear of the same bit in one cycle: set wins.
  - Issue to a busy register not being cleared that cycle sets `o_err`.
  - A B handshake to a non-busy register sets `o_err`.
  - `o_err` is cleared only by `rst`.
- A write to a register whose busy bit is set is legal; the pipeline interlocks on `o_busy` and owns ordering.

## Timing
- Write-port outputs, `o_b_ready` and `o_a_stall` are combinational from the inputs and the FSM state register. Arbitration latency is zero.
- B handshake completes at the rising edge where `b_valid`=1, `o_b_ready`=1 and `gwe`=1.
- When `gwe`=0: `o_b_ready`=0, `o_rd_we` is still driven, and FSM, counter, busy and err hold.
- `o_busy` and `o_err` are registered and change one edge after the triggering cycle.
- While `rst`=1: `o_rd_we`=0, `o_b_ready`=0, `o_a_stall`=0.
- At the first edge with `rst`=1: state=NORMAL, counter=0, `o_busy`=0, `o_err`=0.
- Reset mid-FORCE returns to NORMAL; any pending B is retried from zero count.
- `STARVE_LIMIT`=1 means B is forced on the cycle after any denial.

## Configuration
- `LC4_WB_BYPASS_EN` defined:
  - `o_rs_data` = `o_wdata` when `o_rd_we`=1 and `o_rd`==`i_rs`; otherwise `i_rs_data`.
  - `o_rt_data` follows the same rule with `i_rt` and `i_rt_data`.
- `LC4_WB_BYPASS_EN` undefined: `o_rs_data`=`i_rs_data` and `o_rt_data`=`i_rt_data`. The ports remain present.

## Structure
- Package `lc4_wb_pkg` holds:
  - FSM state encoding (NORMAL=0, FORCE=1);
  - register index width (3) and register count (8);
  - counter width (4).
- All state is held in `Nbit_reg` instances with reset value 0.
- Sub-module `lc4_wb_scoreboard` contains the 8-bit busy mask, the set/clear logic and error detection.

## Test plan
1. Hold `rst` 2 cycles -> `o_busy`=8'h00, `o_rd_we`=0, `o_b_ready`=0, `o_err`=0.
2. `b_issue` rd=3, then `b_valid` rd=3 data=16'h1234 with `a_we`=0 -> `o_b_ready`=1, `o_rd`=3, `o_wdata`=16'h1234, `o_rd_we`=1; `o_busy[3]` goes 1 then 0.
3. `STARVE_LIMIT`=4, `a_we`=1 every cycle, `b_valid` held from cycle 0 -> A granted cycles 0-3; cycle 4 `o_a_stall`=1 and B written; cycle 5 A granted again.
4. Same cycle: B completes rd=5 and `b_issue` rd=5 -> `o_busy[5]` stays 1, `o_err`=0. Then issue rd=5 again -> `o_err`=1.
5. `gwe`=0 with `b_valid`=1, `a_we`=1 for 10 cycles -> no FORCE, `o_busy` unchanged, counter held.
6. With `LC4_WB_BYPASS_EN`: `a_we` rd=1 data=16'h00AA, `i_rs`=1, `i_rs_data`=16'h0000 -> `o_rs_data`=16'h00AA. Without the macro -> `o_rs_data`=16'h0000.
